// File: rtl/conversor_binario_bcd_if.sv
// Handshake and data bundle between the vending datapath and the binary-to-BCD converter.
// The master drives iniciar/valor; the slave (converter) returns status flags and the BCD result.
interface conversor_binario_bcd_if #(
  parameter int LARGURA = 8,
  parameter int DIGITOS = 3
);
  logic                   iniciar;
  logic [LARGURA-1:0]     valor;
  logic                   ocupado;
  logic                   pronto;
  logic                   estouro;
  logic [4*DIGITOS-1:0]   bcd;

  modport master (
    output iniciar, valor,
    input  ocupado, pronto, estouro, bcd
  );

  modport slave (
    input  iniciar, valor,
    output ocupado, pronto, estouro, bcd
  );
endinterface

// File: rtl/conversor_binario_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, result held between runs.
// Latency LARGURA cycles from accepted start to pronto; iniciar is ignored while ocupado.
module conversor_binario_bcd #(
  parameter int LARGURA = 8,
  parameter int DIGITOS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conversor_binario_bcd_if.slave bus
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int BW = 4 * DIGITOS;
  localparam logic [BW-1:0]  NOVES  = {DIGITOS{4'h9}};
  localparam logic [CW-1:0]  ULTIMO = CW'(LARGURA - 1);

  typedef enum logic {OCIOSO, DESLOCA} estado_t;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   bin_q, bin_d;
  logic [BW-1:0]        work_q, work_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic                 estouro_q, estouro_d;
  logic                 pronto_q, pronto_d;
  logic [BW-1:0]        ajuste;

  always_comb begin
    estado_d  = estado_q;
    bin_d     = bin_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    bcd_d     = bcd_q;
    estouro_d = estouro_q;
    pronto_d  = 1'b0;

    // add-3 correction on pre-shift nibbles, all digits in parallel
    for (int i = 0; i < DIGITOS; i++) begin
      ajuste[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                    : work_q[4*i +: 4];
    end

    case (estado_q)
      OCIOSO: begin
        if (bus.iniciar) begin
          bin_d    = bus.valor;
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          estado_d = DESLOCA;
        end
      end
      DESLOCA: begin
        {work_d, bin_d} = {ajuste[BW-2:0], bin_q, 1'b0};
        // any bit leaving the top digit means the value needs more digits than we have
        sticky_d = sticky_q | ajuste[BW-1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == ULTIMO) begin
          estado_d  = OCIOSO;
          pronto_d  = 1'b1;
          estouro_d = sticky_d;
          bcd_d     = sticky_d ? NOVES : work_d;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      bin_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      bcd_q     <= '0;
      estouro_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      bcd_q     <= bcd_d;
      estouro_q <= estouro_d;
      pronto_q  <= pronto_d;
    end
  end

  assign bus.ocupado = (estado_q == DESLOCA);
  assign bus.pronto  = pronto_q;
  assign bus.estouro = estouro_q;
  assign bus.bcd     = bcd_q;

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Bench for conversor_binario_bcd: a 3-digit and a 2-digit instance checked cycle by cycle
// against a handshake model and a scoreboard of reference conversions.
module tb_conversor_binario_bcd;

  localparam int LARG = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        ini [2];
  logic [7:0]  val [2];
  logic        ocup_o [2];
  logic        pr_o [2];
  logic        est_o [2];
  logic [11:0] bcd_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  conversor_binario_bcd_if #(.LARGURA(LARG), .DIGITOS(3)) if0 ();
  conversor_binario_bcd_if #(.LARGURA(LARG), .DIGITOS(2)) if1 ();

  conversor_binario_bcd #(.LARGURA(LARG), .DIGITOS(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  conversor_binario_bcd #(.LARGURA(LARG), .DIGITOS(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.iniciar = ini[0];
  assign if0.valor   = val[0];
  assign if1.iniciar = ini[1];
  assign if1.valor   = val[1];
  assign ocup_o[0] = if0.ocupado;
  assign pr_o[0]   = if0.pronto;
  assign est_o[0]  = if0.estouro;
  assign bcd_o[0]  = if0.bcd;
  assign ocup_o[1] = if1.ocupado;
  assign pr_o[1]   = if1.pronto;
  assign est_o[1]  = if1.estouro;
  assign bcd_o[1]  = {4'h0, if1.bcd};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {estouro, bcd} for a value rendered in d decimal digits, saturated to all 9s
  function automatic logic [12:0] ref_conv(input int v, input int d);
    int          lim;
    int          t;
    logic [11:0] r;
    lim = 1;
    r   = '0;
    for (int i = 0; i < d; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'd9;
      return {1'b1, r};
    end
    t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {1'b0, r};
  endfunction

  // handshake model: cycles left in the running conversion, expected pronto, held result
  int          m_cnt [2]  = '{0, 0};
  logic        m_pr [2]   = '{1'b0, 1'b0};
  logic [12:0] hold [2]   = '{13'h0, 13'h0};
  logic [12:0] sb0 [$];
  logic [12:0] sb1 [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0;
        m_pr[k]  = 1'b0;
        hold[k]  = '0;
      end
      sb0.delete();
      sb1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_pr[k] = 1'b0;
        if (m_cnt[k] > 0) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) m_pr[k] = 1'b1;
        end else if (ini[k]) begin
          m_cnt[k] = LARG;
          if (k == 0) sb0.push_back(ref_conv(int'(val[k]), 3));
          else        sb1.push_back(ref_conv(int'(val[k]), 2));
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ocupado%0d", k), 32'(ocup_o[k]), 32'(m_cnt[k] > 0));
      check($sformatf("pronto%0d", k), 32'(pr_o[k]), 32'(m_pr[k]));
      if (m_pr[k]) begin
        if (k == 0 && sb0.size() > 0)      hold[k] = sb0.pop_front();
        else if (k == 1 && sb1.size() > 0) hold[k] = sb1.pop_front();
        else check($sformatf("sb_empty%0d", k), 32'd0, 32'd1);
      end
      check($sformatf("bcd%0d", k), 32'(bcd_o[k]), 32'(hold[k][11:0]));
      check($sformatf("estouro%0d", k), 32'(est_o[k]), 32'(hold[k][12]));
    end
  end

  task automatic conv(input int k, input int v);
    @(posedge clk); #1;
    ini[k] = 1'b1;
    val[k] = 8'(v);
    @(posedge clk); #1;
    ini[k] = 1'b0;
    repeat (LARG + 1) @(posedge clk);
  endtask

  initial begin
    ini[0] = 1'b0; ini[1] = 1'b0;
    val[0] = 8'd0; val[1] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ocupado", 32'(ocup_o[0]), 32'd0);
    check("rst_pronto",  32'(pr_o[0]),   32'd0);
    check("rst_bcd",     32'(bcd_o[0]),  32'd0);
    check("rst_estouro", 32'(est_o[0]),  32'd0);
    rst_n = 1'b1;

    conv(0, 0);
    conv(0, 255);
    conv(0, 99);
    conv(0, 10);

    // valor changes mid-conversion; iniciar held high is re-accepted in the pronto cycle
    @(posedge clk); #1;
    ini[0] = 1'b1;
    val[0] = 8'd37;
    @(posedge clk); #1;
    val[0] = 8'd200;
    repeat (LARG + 1) @(posedge clk);
    #1;
    ini[0] = 1'b0;
    repeat (LARG + 2) @(posedge clk);

    conv(1, 100);
    conv(1, 42);
    conv(1, 99);

    // reset during iteration 4 of a conversion
    @(posedge clk); #1;
    ini[0] = 1'b1;
    val[0] = 8'd128;
    @(posedge clk); #1;
    ini[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_ocupado", 32'(ocup_o[0]), 32'd0);
    check("midrst_pronto",  32'(pr_o[0]),   32'd0);
    check("midrst_bcd",     32'(bcd_o[0]),  32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    conv(0, 5);

    // back-to-back sweep on both instances
    for (int v = 0; v < 256; v++) begin
      @(posedge clk); #1;
      ini[0] = 1'b1; ini[1] = 1'b1;
      val[0] = 8'(v); val[1] = 8'(v);
      @(posedge clk); #1;
      ini[0] = 1'b0; ini[1] = 1'b0;
      repeat (LARG - 1) @(posedge clk);
    end
    repeat (LARG + 4) @(posedge clk);
    #1;
    check("sb_drain0", 32'(sb0.size()), 32'd0);
    check("sb_drain1", 32'(sb1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
